axi_lite_reg_master: RTL and testbench
======================================

Name: axi_lite_reg_master

Overview:
AXI4-Lite initiator that converts a simple single-outstanding register request/response interface into AXI4-Lite read and write transactions. Used by on-chip agents (test sequencers, control FSMs, loopback harnesses) to drive the AXI-Lite slave ports of the cpu_regs register blocks. One transaction in flight at a time. A programmable timeout reports a hung slave without violating AXI handshake rules.

Parameters:
C_M_AXI_DATA_WIDTH, 32, data width; only 32 supported.
C_M_AXI_ADDR_WIDTH, 32, address width.
C_BASE_ADDRESS, 32'h0000_0000, target block base; issued address = C_BASE_ADDRESS ^ req_addr.
C_TIMEOUT, 1024, cycles from AXI issue to response before timeout is reported; 0 disables the timeout.

Ports:
clk  in  1  single clock for all logic
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_rnw  in  1  1=read, 0=write
req_addr  in  C_M_AXI_ADDR_WIDTH  register offset
req_wdata  in  32  write data
req_wstrb  in  4  write byte strobes
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  out  32  read data; 0 for writes
rsp_resp  out  2  AXI RRESP/BRESP; 2'b10 on timeout
rsp_timeout  out  1  response generated by timeout
M_AXI_AWADDR/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY  AXI4-Lite master channel signals at the standard directions and widths
M_AXI_AWPROT, M_AXI_ARPROT  out  3  tied to 3'b000

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; all *VALID, BREADY, RREADY, rsp_valid, rsp_timeout = 0; rsp_rdata = 0; rsp_resp = 0; timeout counter = 0; req_ready = 1 (combinational, state==IDLE).
- States: IDLE, WR (AW/W outstanding), WR_B, RD_A, RD_R, RSP, DRAIN.
- IDLE: on req accept at cycle N, register addr/data/strb. Write: AWVALID=WVALID=1 at N+1, go WR. Read: ARVALID=1 at N+1, go RD_A.
- WR: AWVALID drops the cycle after AWVALID&&AWREADY; WVALID drops independently after WVALID&&WREADY. AW and W may complete in either order or together. When both are done, BREADY=1, go WR_B.
- WR_B: on BVALID&&BREADY, BREADY=0, latch BRESP, rsp_rdata=0, go RSP.
- RD_A: on ARVALID&&ARREADY, ARVALID=0, RREADY=1, go RD_R. RD_R: on RVALID&&RREADY, latch RDATA/RRESP, RREADY=0, go RSP.
- Minimum latency with a zero-wait slave: req accept N, AXI handshake N+1, B/R handshake N+2, rsp_valid N+3.
- RSP: rsp_valid=1 held with stable payload until rsp_ready. Return to IDLE on handshake, so req_ready is 1 the next cycle. rsp_valid never asserts while any AXI channel is outstanding, except after a timeout.
- Timeout: the counter clears on req accept and increments each cycle in WR/WR_B/RD_A/RD_R. When it reaches C_TIMEOUT: rsp_valid=1, rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=32'hDEADBEEF. All pending VALID/READY stay asserted; go DRAIN.
- DRAIN: finish the AXI transaction protocol-correctly and discard the result. req_ready stays 0 until the transaction completes AND the timeout response is consumed, then return to IDLE.
- Simultaneous: completion on the same cycle the counter hits C_TIMEOUT counts as completion, with no timeout. AW and W handshakes on the same cycle are handled as both done.
- VALID signals never deassert before their handshake, and AXI outputs stay stable while VALID is high.
- Reset mid-transaction: all outputs return to reset values immediately. Bench and slave are reset together.

Test Plan:
- Write req_addr=0x8, wdata=0xA5A5_0001, wstrb=0xF, zero-wait slave -> AWADDR=0x8, WDATA=0xA5A5_0001 at N+1; rsp_valid at N+3 with resp=00, rdata=0, timeout=0.
- Read 0x0 from a slave returning 0x0000_1234 with ARREADY delayed 3 cycles and RVALID delayed 2 -> ARVALID held for 4 cycles; rsp_rdata=0x0000_1234, resp=00.
- Write with WREADY 5 cycles before AWREADY, then the reverse order, then both on the same cycle -> BREADY asserts only after both handshakes; exactly one rsp per request.
- C_TIMEOUT=16, slave never raises BVALID until cycle 40 -> rsp at cycle 16 after issue with resp=10, timeout=1, rdata=0xDEADBEEF; req_ready=0 until B is accepted and the rsp is consumed.
- rsp_ready held low 10 cycles, then a back-to-back read/write/read stream -> payload stable while stalled; no AXI activity until consumed; order preserved.
- resetn asserted during RD_R -> RREADY/ARVALID/rsp_valid=0 asynchronously; after release req_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/axi_lite_reg_master.sv
// rtl/axi_lite_reg_master.sv - AXI4-Lite initiator for single-outstanding register requests
//
// Purpose: turns one register request at a time into an AXI4-Lite read or
// write, returns the slave response, and reports a hung slave after a
// programmable number of cycles while still finishing the AXI handshake.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   req_*                  request channel (valid/ready, rnw, addr, wdata, wstrb)
//   rsp_*                  response channel (valid/ready, rdata, resp, timeout)
//   M_AXI_AW*/W*/B*        AXI4-Lite write address, write data, write response
//   M_AXI_AR*/R*           AXI4-Lite read address, read data
module axi_lite_reg_master #(
  parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDRESS     = '0,
  parameter int unsigned                   C_TIMEOUT          = 1024
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   req_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   req_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] req_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_B, S_RD_A, S_RD_R, S_RSP, S_DRAIN} state_t;

  state_t                            state, state_n;
  logic                              rnw_q, rnw_n;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     addr_q, addr_n;
  logic [C_M_AXI_DATA_WIDTH-1:0]     wdata_q, wdata_n;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb_q, wstrb_n;
  logic                              awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
  // busy: an AXI transaction is issued and its B/R beat has not been taken yet
  logic                              busy_q, busy_n;
  logic [31:0]                       cnt_q, cnt_n;
  logic                              rsp_valid_n, rsp_timeout_n;
  logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata_n;
  logic [1:0]                        rsp_resp_n;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, timeout_hit;

  assign aw_hs = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs  = M_AXI_WVALID  & M_AXI_WREADY;
  assign b_hs  = M_AXI_BVALID  & M_AXI_BREADY;
  assign ar_hs = M_AXI_ARVALID & M_AXI_ARREADY;
  assign r_hs  = M_AXI_RVALID  & M_AXI_RREADY;

  // Fires one cycle early so rsp_valid is registered exactly when the count reaches C_TIMEOUT.
  assign timeout_hit = (C_TIMEOUT != 32'd0) && ((cnt_q + 32'd1) == C_TIMEOUT);

  assign req_ready    = (state == S_IDLE);
  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  always_comb begin
    state_n       = state;
    rnw_n         = rnw_q;
    addr_n        = addr_q;
    wdata_n       = wdata_q;
    wstrb_n       = wstrb_q;
    awvalid_n     = M_AXI_AWVALID;
    wvalid_n      = M_AXI_WVALID;
    bready_n      = M_AXI_BREADY;
    arvalid_n     = M_AXI_ARVALID;
    rready_n      = M_AXI_RREADY;
    busy_n        = busy_q;
    cnt_n         = cnt_q;
    rsp_valid_n   = rsp_valid;
    rsp_timeout_n = rsp_timeout;
    rsp_rdata_n   = rsp_rdata;
    rsp_resp_n    = rsp_resp;

    // Channel sequencing runs in every state so DRAIN finishes the transaction
    // exactly like the normal path would.
    if (aw_hs) awvalid_n = 1'b0;
    if (w_hs)  wvalid_n  = 1'b0;
    if (!rnw_q && busy_q && !M_AXI_BREADY && !awvalid_n && !wvalid_n) bready_n = 1'b1;
    if (b_hs) begin
      bready_n = 1'b0;
      busy_n   = 1'b0;
    end
    if (ar_hs) begin
      arvalid_n = 1'b0;
      rready_n  = 1'b1;
    end
    if (r_hs) begin
      rready_n = 1'b0;
      busy_n   = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          rnw_n   = req_rnw;
          addr_n  = C_BASE_ADDRESS ^ req_addr;
          wdata_n = req_wdata;
          wstrb_n = req_wstrb;
          cnt_n   = 32'd0;
          busy_n  = 1'b1;
          if (req_rnw) begin
            arvalid_n = 1'b1;
            state_n   = S_RD_A;
          end else begin
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
            state_n   = S_WR;
          end
        end
      end
      S_WR, S_WR_B, S_RD_A, S_RD_R: begin
        cnt_n = cnt_q + 32'd1;
        // Completion wins over a timeout landing on the same cycle.
        if (b_hs || r_hs) begin
          rsp_valid_n   = 1'b1;
          rsp_timeout_n = 1'b0;
          rsp_rdata_n   = r_hs ? M_AXI_RDATA : '0;
          rsp_resp_n    = r_hs ? M_AXI_RRESP : M_AXI_BRESP;
          state_n       = S_RSP;
        end else if (timeout_hit) begin
          rsp_valid_n   = 1'b1;
          rsp_timeout_n = 1'b1;
          rsp_rdata_n   = 32'hDEAD_BEEF;
          rsp_resp_n    = 2'b10;
          state_n       = S_DRAIN;
        end else if (state == S_WR && bready_n) begin
          state_n = S_WR_B;
        end else if (state == S_RD_A && ar_hs) begin
          state_n = S_RD_R;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          state_n     = S_IDLE;
        end
      end
      S_DRAIN: begin
        // Late B/R beats are discarded; leave only once both the bus and the
        // timeout response are finished.
        if (rsp_ready) rsp_valid_n = 1'b0;
        if (!busy_n && !rsp_valid_n) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      rnw_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      busy_q        <= 1'b0;
      cnt_q         <= 32'd0;
      rsp_valid     <= 1'b0;
      rsp_timeout   <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
    end else begin
      state         <= state_n;
      rnw_q         <= rnw_n;
      addr_q        <= addr_n;
      wdata_q       <= wdata_n;
      wstrb_q       <= wstrb_n;
      M_AXI_AWVALID <= awvalid_n;
      M_AXI_WVALID  <= wvalid_n;
      M_AXI_BREADY  <= bready_n;
      M_AXI_ARVALID <= arvalid_n;
      M_AXI_RREADY  <= rready_n;
      busy_q        <= busy_n;
      cnt_q         <= cnt_n;
      rsp_valid     <= rsp_valid_n;
      rsp_timeout   <= rsp_timeout_n;
      rsp_rdata     <= rsp_rdata_n;
      rsp_resp      <= rsp_resp_n;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// tb/tb_axi_lite_reg_master.sv - self-checking bench for axi_lite_reg_master
module tb_axi_lite_reg_master;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int unsigned TMO  = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid, req_ready, req_rnw;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  always #5 clk = ~clk;

  axi_lite_reg_master #(
    .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(32),
    .C_BASE_ADDRESS(BASE), .C_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_rnw(req_rnw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  int vectors = 0, miscompares = 0, cyc = 0, n_req = 0, n_rsp = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: ready after a configurable wait, B/R after a configurable delay.
  int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  logic        aw_done, w_done, ar_done;
  logic [31:0] ar_addr_q;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_cnt >= aw_dly);
  assign M_AXI_WREADY  = M_AXI_WVALID && (w_cnt >= w_dly);
  assign M_AXI_BVALID  = aw_done && w_done && (b_cnt >= b_dly);
  assign M_AXI_BRESP   = b_resp_cfg;
  assign M_AXI_ARREADY = M_AXI_ARVALID && (ar_cnt >= ar_dly);
  assign M_AXI_RVALID  = ar_done && (r_cnt >= r_dly);
  assign M_AXI_RDATA   = 32'h0000_1234 ^ {ar_addr_q[15:0], 16'h0000};
  assign M_AXI_RRESP   = r_resp_cfg;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      aw_done <= 1'b0; w_done <= 1'b0; ar_done <= 1'b0; ar_addr_q <= '0;
    end else begin
      aw_cnt <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_cnt + 1 : 0;
      ar_cnt <= (M_AXI_ARVALID && !M_AXI_ARREADY) ? ar_cnt + 1 : 0;
      if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
      if (M_AXI_WVALID && M_AXI_WREADY) w_done <= 1'b1;
      if (aw_done && w_done) b_cnt <= b_cnt + 1;
      if (M_AXI_BVALID && M_AXI_BREADY) begin
        aw_done <= 1'b0; w_done <= 1'b0; b_cnt <= 0;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        ar_done <= 1'b1; ar_addr_q <= M_AXI_ARADDR;
      end
      if (ar_done) r_cnt <= r_cnt + 1;
      if (M_AXI_RVALID && M_AXI_RREADY) begin
        ar_done <= 1'b0; r_cnt <= 0;
      end
    end
  end

  // Scoreboard: responses and AXI address/data beats expected in order.
  typedef struct packed { logic [31:0] rdata; logic [1:0] resp; logic to; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] awq[$], arq[$];
  logic [35:0] wq[$];
  exp_t        mon_e;

  function automatic exp_t mk(input logic [31:0] rd, input logic [1:0] r, input logic to);
    return {rd, r, to};
  endfunction

  function automatic logic [31:0] rd_exp(input logic [31:0] offs);
    logic [31:0] a;
    a = BASE ^ offs;
    return 32'h0000_1234 ^ {a[15:0], 16'h0000};
  endfunction

  logic        p_aw = 0, p_w = 0, p_ar = 0, p_rsp = 0, p_to;
  logic [31:0] p_awaddr, p_araddr, p_rdata;
  logic [35:0] p_w_pl;
  logic [1:0]  p_resp;

  always @(negedge clk) begin
    if (!resetn) begin
      p_aw <= 1'b0; p_w <= 1'b0; p_ar <= 1'b0; p_rsp <= 1'b0;
    end else begin
      if (p_aw)  check("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, p_awaddr});
      if (p_w)   check("w_hold", {M_AXI_WVALID, M_AXI_WSTRB, M_AXI_WDATA}, {1'b1, p_w_pl});
      if (p_ar)  check("ar_hold", {M_AXI_ARVALID, M_AXI_ARADDR}, {1'b1, p_araddr});
      if (p_rsp) check("rsp_hold", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
                       {1'b1, p_to, p_resp, p_rdata});
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        if (awq.size() == 0) check("aw_extra", 1, 0);
        else check("awaddr", M_AXI_AWADDR, awq.pop_front());
        check("awprot", M_AXI_AWPROT, 0);
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        if (wq.size() == 0) check("w_extra", 1, 0);
        else check("wstrb_wdata", {M_AXI_WSTRB, M_AXI_WDATA}, wq.pop_front());
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        if (arq.size() == 0) check("ar_extra", 1, 0);
        else check("araddr", M_AXI_ARADDR, arq.pop_front());
        check("arprot", M_AXI_ARPROT, 0);
      end
      if (M_AXI_BREADY) check("bready_after_aw_w", {aw_done, w_done}, 2'b11);
      if (rsp_valid && !rsp_timeout)
        check("rsp_quiet", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        if (exp_q.size() == 0) check("rsp_extra", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("rsp_payload", {rsp_timeout, rsp_resp, rsp_rdata}, {mon_e.to, mon_e.resp, mon_e.rdata});
        end
      end
      p_aw <= M_AXI_AWVALID && !M_AXI_AWREADY;
      p_awaddr <= M_AXI_AWADDR;
      p_w <= M_AXI_WVALID && !M_AXI_WREADY;
      p_w_pl <= {M_AXI_WSTRB, M_AXI_WDATA};
      p_ar <= M_AXI_ARVALID && !M_AXI_ARREADY;
      p_araddr <= M_AXI_ARADDR;
      p_rsp <= rsp_valid && !rsp_ready;
      p_to <= rsp_timeout; p_resp <= rsp_resp; p_rdata <= rsp_rdata;
    end
  end

  task automatic do_req(input logic rnw, input logic [31:0] offs, input logic [31:0] wd,
                        input logic [3:0] st, input exp_t e, output int acc);
    int t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_rnw = rnw; req_addr = offs; req_wdata = wd; req_wstrb = st;
    exp_q.push_back(e);
    n_req++;
    if (rnw) arq.push_back(BASE ^ offs);
    else begin
      awq.push_back(BASE ^ offs);
      wq.push_back({st, wd});
    end
    while (!req_ready && t < 300) begin @(negedge clk); t++; end
    check("req_accept", t < 300, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || !req_ready) && t < 300) begin @(negedge clk); t++; end
    check(tag, t < 300, 1);
  endtask

  int acc, t, hold;
  logic [31:0] ww;

  initial begin
    req_valid = 1'b0; req_rnw = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {req_ready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY,
                          M_AXI_RREADY, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
                         {1'b1, 7'b0, 2'b00, 32'h0});
    @(negedge clk);
    resetn = 1'b1;

    // Zero-wait write: AW/W at N+1, BREADY at N+2, response at N+3.
    do_req(1'b0, 32'h8, 32'hA5A5_0001, 4'hF, mk(32'h0, 2'b00, 1'b0), acc);
    @(negedge clk); check("wr_n1", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rsp_valid}, 4'b1100);
    @(negedge clk); check("wr_n2", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rsp_valid}, 4'b0010);
    @(negedge clk); check("wr_n3", {M_AXI_BREADY, rsp_valid}, 2'b01);
    wait_idle("wr_done");

    // Read with ARREADY delayed 3 and RVALID delayed 2.
    ar_dly = 3; r_dly = 2;
    do_req(1'b1, 32'h0, 32'h0, 4'h0, mk(rd_exp(32'h0), 2'b00, 1'b0), acc);
    hold = 0; t = 0;
    while (!M_AXI_RREADY && t < 50) begin
      @(negedge clk);
      if (M_AXI_ARVALID) hold++;
      t++;
    end
    check("arvalid_cycles", hold, 4);
    wait_idle("rd_done");

    // Error responses are passed through.
    ar_dly = 0; r_dly = 0; r_resp_cfg = 2'b10; b_resp_cfg = 2'b11;
    do_req(1'b1, 32'h44, 32'h0, 4'h0, mk(rd_exp(32'h44), 2'b10, 1'b0), acc);
    do_req(1'b0, 32'h48, 32'h0BAD_0BAD, 4'h3, mk(32'h0, 2'b11, 1'b0), acc);
    wait_idle("err_done");
    r_resp_cfg = 2'b00; b_resp_cfg = 2'b00;

    // W before AW, AW before W, both together.
    for (int i = 0; i < 3; i++) begin
      aw_dly = (i == 0) ? 5 : (i == 1) ? 0 : 2;
      w_dly  = (i == 0) ? 0 : (i == 1) ? 5 : 2;
      ww = 32'h1000_0000 + i;
      do_req(1'b0, 32'h100 + 4 * i, ww, 4'b0101, mk(32'h0, 2'b00, 1'b0), acc);
      wait_idle("order_done");
    end
    aw_dly = 0; w_dly = 0;

    // Write timeout with the response stalled until B completes.
    b_dly = 40; rsp_ready = 1'b0;
    do_req(1'b0, 32'h10, 32'h1111_2222, 4'hF, mk(32'hDEAD_BEEF, 2'b10, 1'b1), acc);
    t = 0;
    while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    check("tmo_cycle", cyc - acc, TMO);
    check("tmo_payload", {rsp_timeout, rsp_resp, rsp_rdata, req_ready, M_AXI_BREADY},
                         {1'b1, 2'b10, 32'hDEAD_BEEF, 1'b0, 1'b1});
    t = 0;
    while (M_AXI_BREADY && t < 100) begin @(negedge clk); t++; end
    check("tmo_b_done", {M_AXI_BREADY, req_ready, rsp_valid}, 3'b001);
    repeat (3) @(negedge clk);
    check("tmo_wait_rsp", req_ready, 1'b0);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("tmo_ready_after", {req_ready, rsp_valid}, 2'b10);
    wait_idle("tmo_wr_done");
    b_dly = 0;

    // Read timeout with the response taken before R arrives.
    r_dly = 30;
    do_req(1'b1, 32'h20, 32'h0, 4'h0, mk(32'hDEAD_BEEF, 2'b10, 1'b1), acc);
    t = 0;
    while (!rsp_valid && t < 100) begin @(negedge clk); t++; end
    check("tmo_rd_cycle", cyc - acc, TMO);
    @(negedge clk);
    check("tmo_rd_drain", {rsp_valid, req_ready, M_AXI_RREADY}, 3'b001);
    wait_idle("tmo_rd_done");
    r_dly = 0;

    // Stalled response, then a back-to-back read/write/read stream.
    rsp_ready = 1'b0;
    do_req(1'b1, 32'h4, 32'h0, 4'h0, mk(rd_exp(32'h4), 2'b00, 1'b0), acc);
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall", {rsp_valid, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, req_ready}, 5'b10000);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    do_req(1'b1, 32'h30, 32'h0, 4'h0, mk(rd_exp(32'h30), 2'b00, 1'b0), acc);
    do_req(1'b0, 32'h34, 32'hCAFE_F00D, 4'hC, mk(32'h0, 2'b00, 1'b0), acc);
    do_req(1'b1, 32'h38, 32'h0, 4'h0, mk(rd_exp(32'h38), 2'b00, 1'b0), acc);
    wait_idle("stream_done");

    // Reset while waiting for R.
    r_dly = 20;
    do_req(1'b1, 32'h3C, 32'h0, 4'h0, mk(rd_exp(32'h3C), 2'b00, 1'b0), acc);
    t = 0;
    while (!M_AXI_RREADY && t < 50) begin @(negedge clk); t++; end
    #2 resetn = 1'b0;
    #1 check("async_reset", {M_AXI_RREADY, M_AXI_ARVALID, rsp_valid, req_ready}, 4'b0001);
    void'(exp_q.pop_back());
    n_req--;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check("ready_after_reset", req_ready, 1'b1);
    r_dly = 1;
    do_req(1'b1, 32'h40, 32'h0, 4'h0, mk(rd_exp(32'h40), 2'b00, 1'b0), acc);
    wait_idle("post_reset_rd");

    repeat (2) @(negedge clk);
    check("rsp_count", n_rsp, n_req);
    check("sb_empty", exp_q.size() + awq.size() + wq.size() + arq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
